fp16_mul_arbiter: RTL and testbench

FP16_MUL_ARBITER -- requirements
Module: fp16_mul_arbiter

---
 rtl/fp16_mul_arbiter.sv | 136 +++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FP16 multiplier among
// N_REQ requesters and routes each product back to the requester that issued it.

module fp16_mul_arbiter_lane #(
  parameter int IDW = 2,
  parameter int ID  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tag_vld_i,
  input  logic [IDW-1:0] tag_id_i,
  output logic           rsp_valid_o
);
  logic rsp_valid_q;

  always_ff @(posedge clk) begin
    if (rst) rsp_valid_q <= 1'b0;
    else     rsp_valid_q <= tag_vld_i && (tag_id_i == IDW'(ID));
  end

  assign rsp_valid_o = rsp_valid_q;
endmodule

module fp16_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*16-1:0]  req_a,
  input  logic [N_REQ*16-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 hold,
  output logic                 mul_valid,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_result,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt;
  logic [IDW-1:0]      gnt_id;
  logic                acc;
  int                  idx;

  logic                mul_valid_q;
  logic [IDW-1:0]      mul_id_q;
  logic [15:0]         mul_a_q, mul_b_q;
  tag_t [LAT-1:0]      tag_q;
  logic [15:0]         rsp_data_q;
  logic                tag_any;

  // First asserted request at or after ptr, wrapping; nothing while hold/rst.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    acc    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!acc && req_valid[idx] && !hold && !rst) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        acc      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_id_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_valid_q <= acc;
      if (acc) begin
        mul_id_q <= gnt_id;
        mul_a_q  <= req_a[16*gnt_id +: 16];
        mul_b_q  <= req_b[16*gnt_id +: 16];
      end
    end
  end

  // Tag stage LAT-1 lines up with the cycle mul_result carries that issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      tag_q[0] <= '{vld: mul_valid_q, id: mul_id_q};
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      if (tag_q[LAT-1].vld) rsp_data_q <= mul_result;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    fp16_mul_arbiter_lane #(.IDW(IDW), .ID(i)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .tag_vld_i   (tag_q[LAT-1].vld),
      .tag_id_i    (tag_q[LAT-1].id),
      .rsp_valid_o (rsp_valid[i])
    );
  end

  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k < LAT; k++) tag_any = tag_any | tag_q[k].vld;
  end

  assign req_ready = gnt;
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = mul_valid_q | tag_any | (|rsp_valid);
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a behavioural LAT-cycle FP16 multiplier stub.

module tb_fp16_mul_arbiter;
  localparam int N_REQ = 4;
  localparam int LAT   = 3;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*16-1:0] req_a, req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                hold;
  logic                mul_valid;
  logic [15:0]         mul_a, mul_b, mul_result;
  logic [N_REQ-1:0]    rsp_valid;
  logic [15:0]         rsp_data;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  fp16_mul_arbiter #(.N_REQ(N_REQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .hold(hold), .mul_valid(mul_valid), .mul_a(mul_a),
    .mul_b(mul_b), .mul_result(mul_result), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating FP16 multiply, normal operands only.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [21:0] p;
    logic [9:0]  m;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin e = e + 1; m = p[20:11]; end
    else       m = p[19:10];
    return {s, e[4:0], m};
  endfunction

  logic [15:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] prod [4];

  initial begin
    prod[0] = 16'h4000; prod[1] = 16'h4200; prod[2] = 16'h4400; prod[3] = 16'h4600;
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    tick(); tick();

    // reset state; grants forced off during reset
    req_valid = '1; #1;
    chk("rst_ready", req_ready, 4'b0000);
    req_valid = '0; rst = 1'b0;
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    tick();

    // single request on lane 2: 1.0 * 2.0
    req_a[32 +: 16] = 16'h3C00; req_b[32 +: 16] = 16'h4000;
    req_valid = 4'b0100; #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0; #1;
    chk("single_ready_off", req_ready, 4'b0000);
    chk("single_mul_valid", mul_valid, 1);
    chk("single_mul_a", mul_a, 16'h3C00);
    chk("single_mul_b", mul_b, 16'h4000);
    chk("single_busy_t1", busy, 1);
    tick();
    chk("single_mul_valid_t2", mul_valid, 0);
    chk("single_mul_a_hold", mul_a, 16'h3C00);
    tick(); tick();
    chk("single_rsp_t4", rsp_valid, 4'b0000);
    tick();
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_data", rsp_data, 16'h4000);
    chk("single_busy_t5", busy, 1);
    tick();
    chk("single_rsp_off", rsp_valid, 4'b0000);
    chk("single_rsp_data_hold", rsp_data, 16'h4000);
    chk("single_busy_t6", busy, 0);

    // reset pulse returns ptr to 0, then full contention
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = {16'h4200, 16'h4000, 16'h3E00, 16'h3C00};
    req_b = {4{16'h4000}};
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 5) ? 4'b1111 : 4'b0000; #1;
      if (c < 5) chk($sformatf("cont_ready_%0d", c), req_ready, 32'(1) << (c % 4));
      if (c >= 5 && c < 10) begin
        chk($sformatf("cont_rsp_valid_%0d", c), rsp_valid, 32'(1) << ((c - 5) % 4));
        chk($sformatf("cont_rsp_data_%0d", c), rsp_data, prod[(c - 5) % 4]);
      end
      if (c == 10) chk("cont_rsp_off", rsp_valid, 4'b0000);
      tick();
    end

    // ptr=1: grant lane 1 to move ptr to 2, then rotation over 4'b1010
    req_valid = 4'b0010; #1;
    chk("rot_pre_ready", req_ready, 4'b0010);
    tick();
    req_a[48 +: 16] = 16'hC000;
    req_valid = 4'b1010; #1;
    chk("rot_ready_0", req_ready, 4'b1000);
    tick(); #1;
    chk("rot_ready_1", req_ready, 4'b0010);
    chk("rot_mul_a_lane3", mul_a, 16'hC000);
    tick();
    req_valid = '0; #1;
    chk("rot_mul_a_lane1", mul_a, 16'h3E00);
    tick();

    // hold with ptr=2
    hold = 1'b1; req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold_ready_%0d", c), req_ready, 4'b0000);
      tick();
      chk($sformatf("hold_mul_valid_%0d", c), mul_valid, 0);
    end
    hold = 1'b0; #1;
    chk("hold_resume", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("hold_mul_a", mul_a, 16'h4000);
    repeat (8) tick();
    chk("hold_drain_busy", busy, 0);

    // reset mid-flight, ptr=3 so lane 0 wins
    req_a[0 +: 16] = 16'h4200; req_b[0 +: 16] = 16'h3800;
    req_valid = 4'b0001; #1;
    chk("rmid_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1; req_valid = 4'b1111; #1;
    chk("rmid_ready_in_rst", req_ready, 4'b0000);
    tick();
    rst = 1'b0; req_valid = '0; #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_mul_valid", mul_valid, 0);
    chk("rmid_rsp_data", rsp_data, 0);
    for (int c = 3; c <= 10; c++) begin
      chk($sformatf("rmid_no_rsp_%0d", c), rsp_valid, 4'b0000);
      tick();
    end

    // ptr back at 0; drain timing of a lone op: 3.0 * 0.5
    req_valid = 4'b1111; #1;
    chk("drain_ready_ptr0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int d = 1; d <= 5; d++) begin
      chk($sformatf("drain_busy_%0d", d), busy, 1);
      if (d == 5) begin
        chk("drain_rsp_valid", rsp_valid, 4'b0001);
        chk("drain_rsp_data", rsp_data, 16'h3E00);
      end
      tick();
    end
    chk("drain_busy_6", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
